dma_engineer: RTL and testbench
===============================

DMA_ENGINEER -- requirements
Module: dma_engineer

Interface
REQ-001 Parameter DW, default 512, data beat width in bits.
REQ-002 Parameter AW, default 27, address/length width; units are DW-bit words.
REQ-003 Parameter MAX_OUTST, default 8, maximum memory reads in flight (power of 2, 2..64).
REQ-004 Parameter MEM_WORDS, default 2**27, backing memory size in words; used only under REQ-031.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 dma_engineer_req  in  1  transfer request from layer controller; level, held until ack.
REQ-008 dma_engineer_ack  out  1  one-cycle pulse; request accepted.
REQ-009 dma_engineer_start_addr  in  AW  first word address; sampled on the ack cycle.
REQ-010 dma_engineer_length  in  AW  word count; sampled on the ack cycle.
REQ-011 dma_engineer_dout  out  DW  read data beat.
REQ-012 dma_engineer_dout_en  out  1  dout valid; no backpressure from consumer.
REQ-013 dma_engineer_dout_eop  out  1  marks last beat of transfer; coincident with dout_en.
REQ-014 mem_rd_req  out  1  memory read request.
REQ-015 mem_rd_addr  out  AW  memory read word address.
REQ-016 mem_rd_gnt  in  1  request accepted when mem_rd_req && mem_rd_gnt.
REQ-017 mem_rd_dvalid  in  1  read data return, in request order.
REQ-018 mem_rd_data  in  DW  read data.
REQ-019 dma_engineer_err  out  1  one-cycle pulse; transfer rejected (REQ-031 only).

Function
REQ-020 FSM states IDLE, ACK, ISSUE, DRAIN; IDLE->ACK when req sampled high.
REQ-021 ACK: ack=1 for exactly one cycle, latch start_addr/length; length==0 -> IDLE with no beats, no eop; else -> ISSUE.
REQ-022 ISSUE: mem_rd_req=1 while issued<length and outstanding<MAX_OUTST; mem_rd_addr=start+issued, modulo 2**AW.
REQ-023 issued increments on each req&&gnt; ISSUE->DRAIN the cycle the last request is granted.
REQ-024 outstanding counter: +1 on grant, -1 on dvalid, both same cycle -> unchanged; never exceeds MAX_OUTST.
REQ-025 Each mem_rd_dvalid produces exactly one dout beat: dout/dout_en registered, 1-cycle latency from dvalid.
REQ-026 dout_eop=1 on the beat where returned count reaches length; DRAIN->IDLE on that same cycle.
REQ-027 dout holds last value when dout_en=0; dout_en/eop are 0 outside beats.
REQ-028 req asserted during ISSUE/DRAIN ignored; next ack no earlier than the cycle after eop.
REQ-029 dvalid with outstanding==0 is a protocol violation; ignored, no beat emitted.
REQ-030 Back-to-back: new request may be acked the cycle after returning to IDLE; minimum 2 idle cycles between eop and next first beat.

Configuration
REQ-031 Macro DMA_ENGINEER_ADDR_CHECK_EN defined: in ACK, if start_addr+length > MEM_WORDS (AW+1-bit sum), pulse err with ack, issue no reads, -> IDLE.
REQ-032 Macro undefined: no bounds check, err tied 0, addresses wrap modulo 2**AW.

Reset
REQ-033 rst low: FSM IDLE, counters 0, ack/dout_en/dout_eop/mem_rd_req/err 0, dout 0, mem_rd_addr 0, immediately and asynchronously.
REQ-034 Reset mid-transfer aborts; data returning after release with no outstanding reads is discarded per REQ-029.
REQ-035 Outputs become functional the first clk edge after rst deasserts; no request sampled on that edge.

Verification
REQ-036 start=0x100, len=2, gnt=1, dvalid 2 cycles after grant -> ack 1 pulse, addr 0x100,0x101, 2 beats, eop on 2nd only.
REQ-037 len=20, MAX_OUTST=8, dvalid held off 30 cycles -> exactly 8 grants then req low; all 20 beats in order, eop on 20th.
REQ-038 len=0 -> single ack pulse, no mem_rd_req, no dout_en, FSM back to IDLE in 2 cycles.
REQ-039 start=0x7FFFFFE, len=4, macro undefined -> addrs 0x7FFFFFE,0x7FFFFFF,0x0,0x1; with macro, MEM_WORDS=0x1000, start=0xFFE, len=4 -> err+ack, no reads.
REQ-040 rst low during DRAIN with 3 outstanding -> all outputs 0 asynchronously; post-release stray dvalid -> no dout_en.
REQ-041 Random gnt (50%) and dvalid latency 1-10, 200 transfers -> beat count == length each, data matches memory model, never >MAX_OUTST in flight.

Source files
------------

// File: rtl/dma_engineer_if.sv
// Request/response and memory-read bundle for dma_engineer.
// master = DMA engine side, slave = controller + memory side.
interface dma_engineer_if #(
  parameter int DW = 512,
  parameter int AW = 27
);
  logic          dma_engineer_req;
  logic          dma_engineer_ack;
  logic [AW-1:0] dma_engineer_start_addr;
  logic [AW-1:0] dma_engineer_length;
  logic [DW-1:0] dma_engineer_dout;
  logic          dma_engineer_dout_en;
  logic          dma_engineer_dout_eop;
  logic          dma_engineer_err;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_gnt;
  logic          mem_rd_dvalid;
  logic [DW-1:0] mem_rd_data;

  modport master (
    input  dma_engineer_req,
    input  dma_engineer_start_addr,
    input  dma_engineer_length,
    input  mem_rd_gnt,
    input  mem_rd_dvalid,
    input  mem_rd_data,
    output dma_engineer_ack,
    output dma_engineer_dout,
    output dma_engineer_dout_en,
    output dma_engineer_dout_eop,
    output dma_engineer_err,
    output mem_rd_req,
    output mem_rd_addr
  );

  modport slave (
    output dma_engineer_req,
    output dma_engineer_start_addr,
    output dma_engineer_length,
    output mem_rd_gnt,
    output mem_rd_dvalid,
    output mem_rd_data,
    input  dma_engineer_ack,
    input  dma_engineer_dout,
    input  dma_engineer_dout_en,
    input  dma_engineer_dout_eop,
    input  dma_engineer_err,
    input  mem_rd_req,
    input  mem_rd_addr
  );
endinterface

// File: rtl/dma_engineer.sv
// Streaming read DMA: fetches length words from start_addr, emits beats.
// Optional bounds check enabled by macro DMA_ENGINEER_ADDR_CHECK_EN.
module dma_engineer #(
  parameter int DW        = 512,
  parameter int AW        = 27,
  parameter int MAX_OUTST = 8,
  parameter int MEM_WORDS = 2**27
) (
  input logic            clk,
  input logic            rst,
  dma_engineer_if.master bus
);

  localparam int OW = $clog2(MAX_OUTST) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef DMA_ENGINEER_ADDR_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic          armed;
  logic [AW-1:0] start_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] issued;
  logic [AW-1:0] returned;
  logic [OW-1:0] outst;
  logic [AW:0]   sum;
  logic          oob;
  logic          in_ack;
  logic          grant;
  logic          rd_ok;
  logic          last_iss;
  logic          last_ret;

  assign in_ack   = (state == S_ACK);
  assign sum      = {1'b0, bus.dma_engineer_start_addr}
                  + {1'b0, bus.dma_engineer_length};
  assign oob      = CHK_EN && (sum > LIMIT);
  assign grant    = bus.mem_rd_req && bus.mem_rd_gnt;
  assign rd_ok    = bus.mem_rd_dvalid && (outst != '0);
  assign last_iss = grant && (issued + AW'(1) == len_q);
  assign last_ret = rd_ok && (returned + AW'(1) == len_q);

  assign bus.dma_engineer_ack = in_ack;
  assign bus.dma_engineer_err = in_ack && oob;
  assign bus.mem_rd_req  = (state == S_ISSUE)
                        && (issued != len_q)
                        && (outst < OW'(MAX_OUTST));
  assign bus.mem_rd_addr = start_q + issued;

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:
        if (bus.dma_engineer_req && armed) state_d = S_ACK;
      S_ACK:
        if (oob || bus.dma_engineer_length == '0) state_d = S_IDLE;
        else state_d = S_ISSUE;
      S_ISSUE:
        if (last_iss) state_d = S_DRAIN;
      S_DRAIN:
        if (last_ret) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // State, descriptor latch and armed flag (first edge after reset is skipped).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
    end else begin
      state <= state_d;
      armed <= 1'b1;
      if (in_ack) begin
        start_q <= bus.dma_engineer_start_addr;
        len_q   <= bus.dma_engineer_length;
      end
    end
  end

  // Issue / return / in-flight counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued   <= '0;
      returned <= '0;
      outst    <= '0;
    end else begin
      if (in_ack) issued <= '0;
      else if (grant) issued <= issued + AW'(1);
      if (in_ack) returned <= '0;
      else if (rd_ok) returned <= returned + AW'(1);
      case ({grant, rd_ok})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // Registered output beat; data holds between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dma_engineer_dout     <= '0;
      bus.dma_engineer_dout_en  <= 1'b0;
      bus.dma_engineer_dout_eop <= 1'b0;
    end else begin
      bus.dma_engineer_dout_en  <= rd_ok;
      bus.dma_engineer_dout_eop <= last_ret;
      if (rd_ok) bus.dma_engineer_dout <= bus.mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dma_engineer.sv
// Scoreboard bench for dma_engineer: directed transfers plus random traffic.
// A memory responder models grants/latency; a monitor checks each beat.
module tb_dma_engineer;
  localparam int DW = 32;
  localparam int AW = 27;
  localparam int MO = 8;
`ifdef DMA_ENGINEER_ADDR_CHECK_EN
  localparam int MW = 32'h1000;
`else
  localparam int MW = 2**27;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          eop;
  } beat_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_engineer_if #(.DW(DW), .AW(AW)) bus ();

  dma_engineer #(
    .DW(DW), .AW(AW), .MAX_OUTST(MO), .MEM_WORDS(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  rsp_t  pend[$];
  int    cyc = 0;
  int    hold_until = 0;
  int    lat_min = 1;
  int    lat_max = 1;
  int    last_due = 0;
  bit    rnd_gnt = 1'b0;
  int    grants = 0;
  int    inflight = 0;
  int    max_inflight = 0;
  int    beats = 0;
  int    ack_cyc = 0;
  int    err_cyc = 0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {5'b10110, a} ^ {a[15:0], a[26:11]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},  bus.dma_engineer_ack, 0);
    chk({tag, "_req"},  bus.mem_rd_req, 0);
    chk({tag, "_en"},   bus.dma_engineer_dout_en, 0);
    chk({tag, "_eop"},  bus.dma_engineer_dout_eop, 0);
    chk({tag, "_err"},  bus.dma_engineer_err, 0);
    chk({tag, "_dout"}, bus.dma_engineer_dout, 0);
    chk({tag, "_addr"}, bus.mem_rd_addr, 0);
  endtask

  // Memory responder: random/forced grant, in-order delayed return.
  initial begin
    int due;
    bit g;
    bus.mem_rd_gnt    = 1'b0;
    bus.mem_rd_dvalid = 1'b0;
    bus.mem_rd_data   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      g = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.mem_rd_gnt    = g;
      bus.mem_rd_dvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc && cyc >= hold_until) begin
        bus.mem_rd_dvalid = 1'b1;
        bus.mem_rd_data   = pend[0].d;
        void'(pend.pop_front());
        inflight--;
      end
      if (rst && bus.mem_rd_req && g) begin
        due = cyc + int'($urandom_range(lat_min, lat_max));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{due, memf(bus.mem_rd_addr)});
        grants++;
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
  end

  // Monitor: pop the scoreboard on every beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus.dma_engineer_ack) ack_cyc++;
      if (bus.dma_engineer_err) err_cyc++;
      if (bus.dma_engineer_dout_eop && !bus.dma_engineer_dout_en)
        chk("eop_without_en", bus.dma_engineer_dout_eop, 0);
      if (bus.dma_engineer_dout_en) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.dma_engineer_dout_en, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", bus.dma_engineer_dout, e.d);
          chk("beat_eop", bus.dma_engineer_dout_eop, e.eop);
        end
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] st, input logic [AW-1:0] ln);
    for (int i = 0; i < int'(ln); i++)
      exp_q.push_back('{memf(st + AW'(i)), (i == int'(ln) - 1)});
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!bus.dma_engineer_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", bus.dma_engineer_ack, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Full transfer; hold>0 stalls returns and checks the in-flight cap.
  task automatic xfer(input logic [AW-1:0] st, input logic [AW-1:0] ln,
                      input bit exp_err, input int hold);
    int a0, g0, e0;
    a0 = ack_cyc;
    g0 = grants;
    e0 = err_cyc;
    if (!exp_err) push_exp(st, ln);
    @(negedge clk);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = st;
    bus.dma_engineer_length     = ln;
    wait_ack();
    if (hold > 0) hold_until = cyc + hold;
    @(negedge clk);
    bus.dma_engineer_req = 1'b0;
    if (hold > 0) begin
      repeat (24) @(negedge clk);
      chk("grant_cap", grants - g0, MO);
      chk("req_low_at_cap", bus.mem_rd_req, 0);
    end
    wait_drain();
    repeat (2) @(negedge clk);
    chk("ack_one_pulse", ack_cyc - a0, 1);
    chk("err_pulse", err_cyc - e0, exp_err);
    if (exp_err || ln == 0) chk("no_reads", grants - g0, 0);
  endtask

  initial begin
    int g0, b0, n;
    logic [AW-1:0] st, ln;
    bus.dma_engineer_req        = 1'b0;
    bus.dma_engineer_start_addr = '0;
    bus.dma_engineer_length     = '0;
    lat_min = 2;
    lat_max = 2;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");

    // First edge after release must not sample the pending request.
    push_exp(27'h100, 27'd2);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h100;
    bus.dma_engineer_length     = 27'd2;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("no_sample_first_edge", bus.dma_engineer_ack, 0);
    @(negedge clk);
    chk("ack_second_edge", bus.dma_engineer_ack, 1);
    bus.dma_engineer_req = 1'b0;
    @(negedge clk);
    chk("ack_drops", bus.dma_engineer_ack, 0);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("basic_grants", grants, 2);

    // Zero length: ack, back to IDLE, re-ack two cycles later.
    g0 = grants;
    b0 = beats;
    @(negedge clk);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h200;
    bus.dma_engineer_length     = 27'd0;
    wait_ack();
    @(negedge clk);
    chk("len0_ack_low", bus.dma_engineer_ack, 0);
    chk("len0_no_req", bus.mem_rd_req, 0);
    @(negedge clk);
    chk("len0_reack", bus.dma_engineer_ack, 1);
    bus.dma_engineer_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("len0_grants", grants - g0, 0);
    chk("len0_beats", beats - b0, 0);

    // In-flight cap with stalled returns.
    lat_min = 1;
    lat_max = 1;
    xfer(27'h3000, 27'd20, 1'b0, 30);

`ifdef DMA_ENGINEER_ADDR_CHECK_EN
    xfer(27'hFFE, 27'd4, 1'b1, 0);
    xfer(27'hFFC, 27'd4, 1'b0, 0);
`else
    xfer(27'h7FFFFFE, 27'd4, 1'b0, 0);
`endif

    // Reset while draining three outstanding reads.
    g0 = grants;
    @(negedge clk);
    bus.dma_engineer_req        = 1'b1;
    bus.dma_engineer_start_addr = 27'h40;
    bus.dma_engineer_length     = 27'd3;
    wait_ack();
    hold_until = cyc + 40;
    @(negedge clk);
    bus.dma_engineer_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_grants", grants - g0, 3);
    #2 rst = 1'b0;
    #1 chk_idle_outputs("mid_rst");
    exp_q.delete();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    b0 = beats;
    n = 0;
    while (pend.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("stray_returns", pend.size(), 0);
    chk("stray_beats", beats - b0, 0);

    // Random traffic.
    rnd_gnt = 1'b1;
    lat_min = 1;
    lat_max = 10;
    for (int t = 0; t < 200 && bad < 20; t++) begin
      ln = AW'($urandom_range(1, 16));
`ifdef DMA_ENGINEER_ADDR_CHECK_EN
      st = AW'($urandom_range(0, MW - int'(ln)));
`else
      st = AW'($urandom);
`endif
      xfer(st, ln, 1'b0, 0);
    end

    chk("max_inflight_ok", max_inflight <= MO, 1);
`ifdef DMA_ENGINEER_ADDR_CHECK_EN
    chk("err_total", err_cyc, 1);
`else
    chk("err_total", err_cyc, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
